ccff_bitstream_loader: RTL and testbench
========================================

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 42, giving the number of configuration bits in the downstream ccff chain.
REQ-002 SHALL have parameter WORD_W, default 8, giving the host word width in bits.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port pReset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-006 SHALL have port in_data, input, WORD_W bits: bitstream word, MSB shifted first.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts in_data.
REQ-009 SHALL have port ccff_head, output, 1 bit: serial bit to the chain head.
REQ-010 SHALL have port ccff_shift_en, output, 1 bit: chain shifts on the prog_clk edge where it is 1; it gates the chain prog_clk.
REQ-011 SHALL have port ccff_tail, input, 1 bit: serial bit returned from the chain tail.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the load completes.
REQ-014 SHALL have ports rb_data (output, WORD_W bits) and rb_valid (output, 1 bit): readback words; present only when CCFF_READBACK_EN is defined.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-016 SHALL move IDLE->LOAD on start=1, clear the word buffer and load bits_left=CHAIN_LEN.
REQ-017 SHALL move LOAD->DONE in the cycle after the shift that issues bit CHAIN_LEN; DONE SHALL last exactly one cycle and then move to IDLE.
REQ-018 SHALL ignore start while in LOAD or DONE.
REQ-019 SHALL assert in_ready only in LOAD with bits_left>0 and the word buffer either empty or emitting its last bit this cycle, so back-to-back words sustain one bit per cycle.
REQ-020 SHALL load in_data into the word buffer on in_valid && in_ready.
REQ-021 SHALL present the next buffer bit on ccff_head with ccff_shift_en=1 in each LOAD cycle where the buffer is non-empty and bits_left>0, registered so that both change together, and SHALL decrement bits_left once per issued bit.
REQ-022 SHALL hold ccff_shift_en=0 and ccff_head unchanged during an input stall (buffer empty, no in_valid), so the chain does not move.
REQ-023 SHALL discard buffer bits left over when bits_left reaches 0 (a partial last word); their positions are the word's low-order bits.
REQ-024 SHALL drive busy=1 in LOAD and DONE and done=1 only in DONE.
REQ-025 SHALL size all counters as $clog2(CHAIN_LEN+1) and $clog2(WORD_W+1) bits, with no wrap-around possible.

Reset
REQ-026 SHALL, on pReset=1 at any time (including mid-load), asynchronously force IDLE and set in_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, rb_valid=0, rb_data=0, and clear the buffer and counters.
REQ-027 SHALL require a new start after reset; the aborted chain contents are undefined.

Configuration
REQ-028 SHALL use macro CCFF_READBACK_EN: when it is defined, ccff_tail is sampled in each cycle where ccff_shift_en=1 and deserialised MSB-first into rb_data, with rb_valid pulsed one cycle per full word and the final partial word emitted in the DONE cycle, zero-padded in its low bits; rb_valid has no backpressure.
REQ-029 SHALL, when CCFF_READBACK_EN is undefined, omit rb_data, rb_valid and all readback logic, and leave ccff_tail unused.

Verification
REQ-030 SHALL cover a nominal load: CHAIN_LEN=42, WORD_W=8, start, six words 0xA5 supplied back-to-back -> 42 contiguous ccff_shift_en cycles, ccff_head bits 1,0,1,0,0,1,0,1,..., the last 6 bits of word 6 discarded, one done pulse, busy returns to 0.
REQ-031 SHALL cover an input stall: in_valid dropped for 5 cycles after word 2 -> ccff_shift_en=0 for those cycles, 42 shifts in total, chain model contents correct.
REQ-032 SHALL cover reset mid-load: pReset asserted after bit 20 -> all outputs at reset values immediately, and a following start loads the full 42 bits.
REQ-033 SHALL cover start during a load: a start pulse at bit 10 -> ignored, exactly one done pulse.
REQ-034 SHALL cover readback (macro defined): chain model preloaded with 42 ones, then a load -> rb_valid five times with rb_data=0xFF and a sixth time in DONE with rb_data=0xC0.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams host words MSB-first into a ccff configuration chain.
// Optional readback of the chain tail is enabled by defining CCFF_READBACK_EN.
module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 42,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done
`ifdef CCFF_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
`endif
);
   localparam int LW = $clog2(CHAIN_LEN + 1);
   localparam int CW = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state;
   logic [WORD_W-1:0] word_buf;
   logic [CW-1:0]     buf_cnt;
   logic [LW-1:0]     bits_left;
   logic              issue;
   logic              last_bit;
   logic              accept;

   assign issue    = state == LOAD && buf_cnt != '0 && bits_left != '0;
   assign last_bit = issue && bits_left == LW'(1);
   // A refill on the last buffered bit is skipped when that bit also ends the chain.
   assign in_ready = state == LOAD &&
                     ((buf_cnt == '0 && bits_left != '0) || (buf_cnt == CW'(1) && issue && !last_bit));
   assign accept   = in_valid && in_ready;

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state         <= IDLE;
         word_buf      <= '0;
         buf_cnt       <= '0;
         bits_left     <= '0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         ccff_shift_en <= issue;
         if (issue)
            ccff_head <= word_buf[WORD_W-1];
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  busy      <= 1'b1;
                  word_buf  <= '0;
                  buf_cnt   <= '0;
                  bits_left <= LW'(CHAIN_LEN);
               end
            end
            LOAD: begin
               if (issue)
                  bits_left <= bits_left - LW'(1);
               if (last_bit) begin
                  word_buf <= '0;
                  buf_cnt  <= '0;
               end else if (accept) begin
                  word_buf <= in_data;
                  buf_cnt  <= CW'(WORD_W);
               end else if (issue) begin
                  word_buf <= {word_buf[WORD_W-2:0], 1'b0};
                  buf_cnt  <= buf_cnt - CW'(1);
               end
               if (bits_left == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CCFF_READBACK_EN
   logic [WORD_W-1:0] rb_sr;
   logic [WORD_W-1:0] rb_nxt;
   logic [CW-1:0]     rb_cnt;
   logic [CW-1:0]     rb_cnt_nxt;
   logic [CW-1:0]     rb_pad;

   always_comb begin
      rb_nxt     = ccff_shift_en ? {rb_sr[WORD_W-2:0], ccff_tail} : rb_sr;
      rb_cnt_nxt = ccff_shift_en ? rb_cnt + CW'(1) : rb_cnt;
      rb_pad     = CW'(WORD_W) - rb_cnt_nxt;
   end

   // The final shift lands on the LOAD->DONE edge, so the partial word appears in DONE.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         rb_sr    <= '0;
         rb_cnt   <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (state == IDLE && start) begin
            rb_sr  <= '0;
            rb_cnt <= '0;
         end else if (rb_cnt_nxt == CW'(WORD_W)) begin
            rb_data  <= rb_nxt;
            rb_valid <= 1'b1;
            rb_sr    <= '0;
            rb_cnt   <= '0;
         end else if (state == LOAD && bits_left == '0) begin
            if (rb_cnt_nxt != '0) begin
               rb_data  <= rb_nxt << rb_pad;
               rb_valid <= 1'b1;
            end
            rb_sr  <= '0;
            rb_cnt <= '0;
         end else begin
            rb_sr  <= rb_nxt;
            rb_cnt <= rb_cnt_nxt;
         end
      end
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: scoreboard bench with a behavioural ccff chain model.
module tb_ccff_bitstream_loader;
   localparam int CL = 42;
   localparam int W  = 8;

   logic         prog_clk = 1'b0;
   logic         pReset   = 1'b0;
   logic         start    = 1'b0;
   logic [W-1:0] in_data  = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         ccff_head;
   logic         ccff_shift_en;
   logic         ccff_tail;
   logic         busy;
   logic         done;
`ifdef CCFF_READBACK_EN
   logic [W-1:0] rb_data;
   logic         rb_valid;
`endif

   ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
      .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done)
`ifdef CCFF_READBACK_EN
      , .rb_data(rb_data), .rb_valid(rb_valid)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   logic [CL-1:0] chain = '0;
   logic          preload = 1'b0;
   always @(posedge prog_clk)
      if (preload) chain <= '1;
      else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
   assign ccff_tail = chain[CL-1];

   int   compared = 0, mismatched = 0;
   int   cyc = 0, nshift = 0, first_sh = 0, last_sh = 0, ndone = 0;
   logic abort = 1'b0;
   logic rb_on = 1'b0;
   bit         q_head[$];
   logic [8:0] q_rb[$];

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge prog_clk) begin
      cyc++;
      if (!pReset && ccff_shift_en) begin
         if (q_head.size() == 0) check("extra_shift", 1, 0);
         else check("head_bit", ccff_head, q_head.pop_front());
         if (nshift == 0) first_sh = cyc;
         last_sh = cyc;
         nshift++;
      end
      if (done) begin
         ndone++;
         check("busy_in_done", busy, 1);
      end
`ifdef CCFF_READBACK_EN
      if (rb_valid && rb_on) begin
         if (q_rb.size() == 0) check("extra_rb", 1, 0);
         else begin
            logic [8:0] e;
            e = q_rb.pop_front();
            check("rb_data", rb_data, e[7:0]);
            check("rb_in_done", done, e[8]);
         end
      end
`endif
   end

   task automatic clear_stats();
      nshift = 0; ndone = 0; first_sh = 0; last_sh = 0;
   endtask

   task automatic push_exp(input logic [6*W-1:0] cat);
      for (int i = 0; i < CL; i++) q_head.push_back(cat[6*W-1-i]);
   endtask

   task automatic do_start();
      @(negedge prog_clk) start = 1'b1;
      @(negedge prog_clk) start = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] w);
      int tmo = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && !abort && tmo < 200) begin
         @(negedge prog_clk);
         tmo++;
      end
      if (abort) return;
      if (tmo >= 200) check("send_timeout", 1, 0);
      @(posedge prog_clk);
      @(negedge prog_clk);
   endtask

   task automatic feed(input logic [6*W-1:0] cat, input int stall_after, input int stall);
      for (int k = 0; k < 6; k++) begin
         if (abort) break;
         if (k == stall_after + 1) begin
            int tmo = 0;
            in_valid = 1'b0;
            while (!in_ready && !abort && tmo < 200) begin
               @(negedge prog_clk);
               tmo++;
            end
            repeat (stall) @(negedge prog_clk);
         end
         send(cat[6*W-1-8*k -: 8]);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_shifts(input int n);
      int tmo = 0;
      while (nshift < n && tmo < 300) begin
         @(negedge prog_clk);
         tmo++;
      end
      if (tmo >= 300) check("shift_wait_timeout", nshift, n);
   endtask

   task automatic finish_load(input logic [CL-1:0] exp_chain, input int exp_gap);
      int tmo = 0;
      while (ndone == 0 && tmo < 400) begin
         @(negedge prog_clk);
         tmo++;
      end
      repeat (3) @(negedge prog_clk);
      check("done_pulses", ndone, 1);
      check("shift_count", nshift, CL);
      check("shift_gap", last_sh - first_sh + 1 - nshift, exp_gap);
      check("busy_after", busy, 0);
      check("chain", chain, exp_chain);
      check("head_queue_left", q_head.size(), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready, 0);
      check("rst_head", ccff_head, 0);
      check("rst_shift_en", ccff_shift_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef CCFF_READBACK_EN
      check("rst_rb_valid", rb_valid, 0);
      check("rst_rb_data", rb_data, 0);
`endif
   endtask

   logic [6*W-1:0] cat;

   initial begin
      #1 pReset = 1'b1;
      #1 check_reset_outputs();
      @(negedge prog_clk);
      @(negedge prog_clk) pReset = 1'b0;

      // nominal: six 0xA5 words back-to-back
      cat = 48'hA5A5_A5A5_A5A5;
      clear_stats(); push_exp(cat);
      do_start();
      check("busy_in_load", busy, 1);
      feed(cat, -1, 0);
      finish_load(cat[6*W-1 -: CL], 0);

      // input stall of 5 cycles after word 2
      cat = 48'h3C81_F00F_6699;
      clear_stats(); push_exp(cat);
      do_start();
      feed(cat, 1, 5);
      finish_load(cat[6*W-1 -: CL], 5);

      // reset mid-load, then a full load
      cat = 48'hA5A5_A5A5_A5A5;
      clear_stats(); push_exp(cat);
      do_start();
      fork
         feed(cat, -1, 0);
         begin
            wait_shifts(20);
            pReset = 1'b1;
            abort  = 1'b1;
            #1 check_reset_outputs();
         end
      join
      q_head.delete();
      @(negedge prog_clk) pReset = 1'b0;
      abort = 1'b0;
      cat = 48'h1234_5678_9ABC;
      clear_stats(); push_exp(cat);
      do_start();
      feed(cat, -1, 0);
      finish_load(cat[6*W-1 -: CL], 0);

      // start pulse during a load is ignored
      cat = 48'hC3E7_0155_AA18;
      clear_stats(); push_exp(cat);
      do_start();
      fork
         feed(cat, -1, 0);
         begin
            wait_shifts(10);
            start = 1'b1;
            @(negedge prog_clk) start = 1'b0;
         end
      join
      finish_load(cat[6*W-1 -: CL], 0);

`ifdef CCFF_READBACK_EN
      // readback of a chain preloaded with ones
      @(negedge prog_clk) preload = 1'b1;
      @(negedge prog_clk) preload = 1'b0;
      for (int i = 0; i < 5; i++) q_rb.push_back(9'h0FF);
      q_rb.push_back(9'h1C0);
      rb_on = 1'b1;
      cat = '0;
      clear_stats(); push_exp(cat);
      do_start();
      feed(cat, -1, 0);
      finish_load('0, 0);
      check("rb_queue_left", q_rb.size(), 0);
      rb_on = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
